// File: rtl/transpose_tile_loader.sv
// transpose_tile_loader: assembles row-serial input into a zero-padded tile held stable for the transpose stage
module transpose_tile_loader #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_PE = 8,
  parameter int NUM_MG = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_row [0:NUM_PE-1],
  input  logic                  in_last,
  input  logic                  in_transpose,
  output logic [DATA_WIDTH-1:0] tile_elements [0:NUM_MG-1][0:NUM_PE-1],
  output logic                  tile_ctrl,
  output logic                  tile_valid,
  input  logic                  tile_ready,
  output logic [$clog2(NUM_MG+1)-1:0] tile_rows
);
  localparam int CW = $clog2(NUM_MG+1);
  typedef enum logic {FILL, FULL} state_t;
  state_t state, state_n;
  logic [CW-1:0] row_cnt;
  logic accept, done, hs;
  if (NUM_MG != NUM_PE) begin : g_bad_shape
    $error("transpose_tile_loader: NUM_MG must equal NUM_PE");
  end
  assign accept = in_valid && in_ready;
  assign done   = accept && (in_last || row_cnt == CW'(NUM_MG-1));
  assign hs     = tile_valid && tile_ready;
  // state register
  always_ff @(posedge clk)
    state <= rst ? FILL : state_n;
  // leave FILL on the closing row, leave FULL on the tile handshake
  always_comb
    state_n = (state == FILL) ? (done ? FULL : FILL) : (tile_ready ? FILL : FULL);
  // handshake outputs decoded from state; reset blocks any accept
  always_comb begin
    in_ready   = (state == FILL) && !rst;
    tile_valid = (state == FULL);
  end
  // row pointer restarts after each closed tile
  always_ff @(posedge clk)
    if (rst) row_cnt <= '0;
    else if (accept) row_cnt <= done ? '0 : row_cnt + 1'b1;
  // tile buffer: cleared on reset/handshake so unwritten rows read as zero padding
  always_ff @(posedge clk)
    if (rst || hs) begin
      for (int r = 0; r < NUM_MG; r++)
        for (int c = 0; c < NUM_PE; c++)
          tile_elements[r][c] <= '0;
      tile_ctrl <= 1'b0;
      tile_rows <= '0;
    end else if (accept) begin
      for (int r = 0; r < NUM_MG; r++)
        if (row_cnt == CW'(r))
          for (int c = 0; c < NUM_PE; c++)
            tile_elements[r][c] <= in_row[c];
      if (row_cnt == '0) tile_ctrl <= in_transpose;
      if (done) tile_rows <= row_cnt + 1'b1;
    end
endmodule

// File: tb/tb_transpose_tile_loader.sv
// tb_transpose_tile_loader: directed table plus hand sequences for the tile loader
module tb_transpose_tile_loader;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, in_last, in_transpose;
  logic tile_ctrl, tile_valid, tile_ready;
  logic [63:0] in_row [0:7];
  logic [63:0] tile_elements [0:7][0:7];
  logic [3:0] tile_rows;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic rst, iv, il, it, tr;
    logic [63:0] base;
    logic ir, tv, tc;
    logic [3:0] rows;
    logic [63:0] r0c0, r2c7;
  } vec_t;
  vec_t vt [12];

  transpose_tile_loader #(.DATA_WIDTH(64), .NUM_PE(8), .NUM_MG(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
    .in_last(in_last), .in_transpose(in_transpose), .tile_elements(tile_elements),
    .tile_ctrl(tile_ctrl), .tile_valid(tile_valid), .tile_ready(tile_ready), .tile_rows(tile_rows)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_row(input logic [63:0] base);
    for (int c = 0; c < 8; c++) in_row[c] = base + 64'(c);
  endtask

  task automatic check_tile(input string nm, input int nrows, input int off);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        chk($sformatf("%s[%0d][%0d]", nm, r, c), tile_elements[r][c],
            (r < nrows) ? 64'(8*r + c + off) : 64'd0);
  endtask

  task automatic fill(input int n, input int off, input logic it0, input logic use_last);
    for (int r = 0; r < n; r++) begin
      set_row(64'(8*r + off));
      in_valid = 1'b1;
      in_transpose = (r == 0) ? it0 : ~it0;
      in_last = use_last && (r == n-1);
      chk("fill_ready", in_ready, 1'b1);
      tick();
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    in_transpose = 1'b0;
  endtask

  task automatic handshake;
    tile_ready = 1'b1;
    in_valid = 1'b0;
    tick();
    tile_ready = 1'b0;
  endtask

  initial begin
    logic [19:0] mask;
    int k;
    vt[0]  = '{0,1,0,0,1, 64'h10, 1,0,0,4'd0, 64'h0,  64'h0};
    vt[1]  = '{0,0,0,0,1, 64'h99, 1,0,0,4'd0, 64'h10, 64'h0};
    vt[2]  = '{0,1,0,1,0, 64'h20, 1,0,0,4'd0, 64'h10, 64'h0};
    vt[3]  = '{0,1,1,0,0, 64'h30, 1,0,0,4'd0, 64'h10, 64'h0};
    vt[4]  = '{0,1,0,0,0, 64'h40, 0,1,0,4'd3, 64'h10, 64'h37};
    vt[5]  = '{0,1,0,1,1, 64'h40, 0,1,0,4'd3, 64'h10, 64'h37};
    vt[6]  = '{0,1,1,1,0, 64'h40, 1,0,0,4'd0, 64'h0,  64'h0};
    vt[7]  = '{0,0,0,0,0, 64'h40, 0,1,1,4'd1, 64'h40, 64'h0};
    vt[8]  = '{0,0,0,0,1, 64'h40, 0,1,1,4'd1, 64'h40, 64'h0};
    vt[9]  = '{0,0,0,0,0, 64'h40, 1,0,0,4'd0, 64'h0,  64'h0};
    vt[10] = '{1,1,0,1,0, 64'h50, 0,0,0,4'd0, 64'h0,  64'h0};
    vt[11] = '{0,0,0,0,0, 64'h50, 1,0,0,4'd0, 64'h0,  64'h0};

    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_transpose = 1'b0; tile_ready = 1'b0;
    set_row(64'h0);
    tick(); tick();
    chk("rst_ready", in_ready, 1'b0);
    chk("rst_valid", tile_valid, 1'b0);
    chk("rst_ctrl", tile_ctrl, 1'b0);
    chk("rst_rows", tile_rows, 4'd0);
    check_tile("rst_tile", 0, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", in_ready, 1'b1);

    for (int i = 0; i < 12; i++) begin
      rst = vt[i].rst; in_valid = vt[i].iv; in_last = vt[i].il;
      in_transpose = vt[i].it; tile_ready = vt[i].tr;
      set_row(vt[i].base);
      #1;
      chk($sformatf("v%0d_ready", i), in_ready, vt[i].ir);
      chk($sformatf("v%0d_valid", i), tile_valid, vt[i].tv);
      chk($sformatf("v%0d_ctrl", i), tile_ctrl, vt[i].tc);
      chk($sformatf("v%0d_rows", i), tile_rows, vt[i].rows);
      chk($sformatf("v%0d_r0c0", i), tile_elements[0][0], vt[i].r0c0);
      chk($sformatf("v%0d_r2c7", i), tile_elements[2][7], vt[i].r2c7);
      tick();
    end
    rst = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_transpose = 1'b0; tile_ready = 1'b0;

    // full tile with mode captured from row 0 only
    fill(8, 0, 1'b1, 1'b0);
    chk("full_ready", in_ready, 1'b0);
    chk("full_valid", tile_valid, 1'b1);
    chk("full_rows", tile_rows, 4'd8);
    chk("full_ctrl", tile_ctrl, 1'b1);
    check_tile("full", 8, 0);

    // handshake bubble with in_valid held across the boundary
    set_row(64'd100); in_valid = 1'b1; in_transpose = 1'b0; tile_ready = 1'b1;
    chk("bub_ready", in_ready, 1'b0);
    tick();
    tile_ready = 1'b0;
    chk("bub_valid", tile_valid, 1'b0);
    chk("bub_ready2", in_ready, 1'b1);
    chk("bub_rows", tile_rows, 4'd0);
    chk("bub_ctrl", tile_ctrl, 1'b0);
    check_tile("bub_clear", 0, 0);
    tick();
    check_tile("bub_row0", 1, 100);
    for (int r = 1; r < 8; r++) begin
      set_row(64'(8*r + 100));
      in_transpose = 1'b1;
      tick();
    end
    in_valid = 1'b0; in_transpose = 1'b0;
    chk("t2_valid", tile_valid, 1'b1);
    chk("t2_ctrl", tile_ctrl, 1'b0);
    chk("t2_rows", tile_rows, 4'd8);
    check_tile("t2", 8, 100);
    handshake();

    // partial tile held under backpressure with upstream still offering a row
    fill(3, 300, 1'b0, 1'b1);
    chk("part_rows", tile_rows, 4'd3);
    chk("part_ctrl", tile_ctrl, 1'b0);
    set_row(64'd999); in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("hold_ready", in_ready, 1'b0);
      chk("hold_valid", tile_valid, 1'b1);
      tick();
    end
    chk("hold_rows", tile_rows, 4'd3);
    check_tile("part", 3, 300);
    handshake();

    // stalled input: 8 valid cycles out of 20, tile_ready high throughout fill
    mask = 20'b1000_1010_0100_1001_0101;
    k = 0;
    tile_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      in_valid = mask[c];
      in_transpose = (k == 0);
      if (mask[c]) set_row(64'(8*k + 200));
      else set_row(64'hdead);
      tick();
      if (mask[c]) k++;
    end
    in_valid = 1'b0; tile_ready = 1'b0;
    chk("stall_valid", tile_valid, 1'b1);
    chk("stall_rows", tile_rows, 4'd8);
    chk("stall_ctrl", tile_ctrl, 1'b1);
    check_tile("stall", 8, 200);
    handshake();

    // reset mid-fill
    fill(4, 400, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    chk("rf_ready_in_rst", in_ready, 1'b0);
    chk("rf_valid", tile_valid, 1'b0);
    chk("rf_ctrl", tile_ctrl, 1'b0);
    chk("rf_rows", tile_rows, 4'd0);
    check_tile("rf", 0, 0);
    rst = 1'b0;
    #1;
    chk("rf_ready", in_ready, 1'b1);

    // reset while presenting a tile
    fill(8, 500, 1'b1, 1'b0);
    chk("rq_valid_before", tile_valid, 1'b1);
    rst = 1'b1;
    tick();
    chk("rq_valid", tile_valid, 1'b0);
    chk("rq_ctrl", tile_ctrl, 1'b0);
    chk("rq_rows", tile_rows, 4'd0);
    check_tile("rq", 0, 0);
    rst = 1'b0;
    #1;
    chk("rq_ready", in_ready, 1'b1);
    fill(8, 600, 1'b0, 1'b0);
    chk("after_valid", tile_valid, 1'b1);
    chk("after_rows", tile_rows, 4'd8);
    chk("after_ctrl", tile_ctrl, 1'b0);
    check_tile("after", 8, 600);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/transpose_tile_loader.md
Name: transpose_tile_loader

Overview:
Upstream feeder for the single-cycle matrix transpose stage. It accepts a row-serial stream over a valid/ready handshake and assembles NUM_MG rows of NUM_PE elements into a tile register. It then presents the full tile, plus the per-tile transpose control bit, stable on the transpose stage's element-array and ctrl inputs until a downstream controller acknowledges it. Partial tiles, terminated by in_last, are zero-padded.

Parameters:
DATA_WIDTH, 64, width of one element (equals the transpose chunk width when NUM_MG == NUM_PE).
NUM_PE, 8, elements per row (columns).
NUM_MG, 8, rows per tile. NUM_MG == NUM_PE is required; elaboration fails otherwise.

Ports:
clk  input  1  clock.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  in_row carries a valid row.
in_ready  output  1  loader can accept a row this cycle.
in_row  input  [DATA_WIDTH-1:0] x [0:NUM_PE-1]  one row; in_row[j] is column j.
in_last  input  1  this row ends the tile (qualified by in_valid).
in_transpose  input  1  tile mode; sampled on the first accepted row of each tile.
tile_elements  output  [DATA_WIDTH-1:0] x [0:NUM_MG-1][0:NUM_PE-1]  assembled tile.
tile_ctrl  output  1  captured transpose mode; drives transpose stage ctrl.
tile_valid  output  1  tile complete and stable.
tile_ready  input  1  downstream accepts the tile (qualified by tile_valid).
tile_rows  output  $clog2(NUM_MG+1)  number of real rows in the presented tile (1..NUM_MG).

Behaviour:
- States: FILL, FULL. Registered row counter row_cnt of width $clog2(NUM_MG+1).
- Reset (rst high at posedge):
  - state <= FILL, row_cnt <= 0.
  - All tile_elements <= 0; tile_ctrl <= 0; tile_valid <= 0; tile_rows <= 0.
  - in_ready is forced 0 while rst is high.
  - Reset mid-fill or mid-FULL discards the partial or presented tile; no handshake completes in that cycle.
- in_ready = (state == FILL) && !rst. tile_valid = (state == FULL).
- Accept is in_valid && in_ready. On accept:
  - tile_elements[row_cnt][j] <= in_row[j] for all j.
  - If row_cnt == 0, tile_ctrl <= in_transpose. in_transpose on later rows is ignored.
  - If in_last or row_cnt == NUM_MG-1: state <= FULL, tile_rows <= row_cnt+1, row_cnt <= 0.
  - Otherwise row_cnt <= row_cnt+1.
- in_last on the NUM_MG-th row is redundant; the behaviour is identical to that row without in_last.
- Rows never written in a tile read 0 (zero-padding). The buffer is cleared to 0 at reset and at every tile handshake.
- FULL:
  - in_ready = 0.
  - tile_elements, tile_ctrl and tile_rows hold stable for the entire time tile_valid is high.
  - On tile_valid && tile_ready: state <= FILL, all tile_elements <= 0, tile_ctrl <= 0, tile_rows <= 0.
  - No row is accepted in the handshake cycle. The earliest next accept is the following cycle, so there is a 1-cycle bubble per tile.
- Latency: the first row accepted at edge t0 of a full tile gives tile_valid high after edge t0+NUM_MG-1 (cycle after the last accept), assuming in_valid is held continuously. Peak throughput is NUM_MG rows per NUM_MG+1 cycles.
- tile_ready while not FULL has no effect. in_valid while in_ready is low has no effect; the upstream must hold the row (standard valid/ready, no drop).
- in_last with in_valid low is ignored.
- All outputs are registered except in_ready and tile_valid, which are decoded from the state register.

Test Plan:
- Full tile: reset, then 8 back-to-back rows in_row[j] = 8*r+j, in_transpose = 1 on row 0. Expected: in_ready drops after the 8th accept; tile_valid = 1, tile_rows = 8, tile_ctrl = 1, tile_elements[r][j] = 8*r+j.
- Partial tile: 3 rows with in_last on row 2, in_transpose = 0. Expected: tile_rows = 3, rows 3..7 all 0, tile_ctrl = 0. Hold tile_ready = 0 for 5 cycles; tile stays stable and in_ready stays 0 throughout.
- Handshake bubble: in_valid held high across a tile boundary, tile_ready pulsed in FULL. Expected: no accept in the handshake cycle; the next tile's row 0 is accepted the following cycle into tile_elements[0]; the rest of the buffer is zero.
- Mode capture: in_transpose = 1 on row 0, then 0 on rows 1..7. Expected: tile_ctrl = 1. A following tile with row 0 in_transpose = 0 presents tile_ctrl = 0.
- Backpressure and stalls: random in_valid gaps (valid on 8 of 20 cycles). Expected: rows land in order at indices 0..7 with no duplicates or drops; tile_ready asserted outside FULL has no effect.
- Reset mid-operation: assert rst after 4 rows, and separately while in FULL. Expected: next cycle all outputs are 0, row_cnt = 0, in_ready = 1 after rst deasserts; the subsequent full tile is correct.
